// File: rtl/fetch_queue_if.sv
// Fetch-to-decode and fetch-to-imem signal bundle.
// master = fetch stage, slave = memory/decode/execute side.
interface fetch_queue_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus8;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pcplus8, fetch_count,
        input  imem_rd, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pcplus8, fetch_count,
        output imem_rd, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, captures {pc, instr} into a small FIFO
// and hands entries to decode over valid/ready; a redirect flushes and reloads.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_st_pc    [DEPTH];
    logic [31:0]   r_st_instr [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_redirect_tgt;

    assign w_pop          = bus.out_valid && bus.out_ready;
    assign w_push         = !bus.redirect && ((r_count < CW'(DEPTH)) || w_pop);
    assign w_redirect_tgt = bus.redirect_pc & ~32'd3;

    assign bus.imem_addr   = r_pc;
    assign bus.out_valid   = (r_count != '0);
    assign bus.out_pc      = r_st_pc[r_head];
    assign bus.out_instr   = r_st_instr[r_head];
    assign bus.out_pcplus8 = r_st_pc[r_head] + 32'd8;
    assign bus.fetch_count = r_fetch_count;

    // Control state: reset beats redirect, redirect beats the handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_fetch_count <= '0;
        end else if (bus.redirect) begin
            r_pc    <= w_redirect_tgt;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc          <= r_pc + 32'd4;
                r_tail        <= r_tail + 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Payload storage needs no reset; validity lives entirely in r_count.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_st_pc[r_tail]    <= r_pc;
            r_st_instr[r_tail] <= bus.imem_rd;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, backpressure, full+pop,
// redirect, back-to-back redirect, PC wrap and mid-stream reset.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset_n;
    logic reset2_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fetch_queue_if bus ();
    fetch_queue_if bus2 ();

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );
    fetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_dut_wrap (
        .clk(clk), .reset_n(reset2_n), .bus(bus2.master)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'hE3A0_9000;
            32'h0000_0004: imem = 32'hE3A0_00C8;
            32'h0000_0008: imem = 32'hE3A0_1001;
            32'h0000_005C: imem = 32'hEAFF_FFFE;
            default:       imem = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign bus.imem_rd  = imem(bus.imem_addr);
    assign bus2.imem_rd = imem(bus2.imem_addr);

    // Advance one edge, then settle before anyone looks at outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n         = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = ready;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr); end
        n_checks++;
        if (bus.fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_fcnt: got %0d expected 0", bus.fetch_count); end
    endtask

    task automatic test_stream();
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'hE3A0_9000 || bus.out_pcplus8 !== 32'h8) begin
            n_errors++;
            $display("FAIL stream_first: got v=%b pc=%h ins=%h p8=%h expected 1/00000000/E3A09000/00000008",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.out_pcplus8);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 || bus.out_instr !== 32'hE3A0_00C8) begin
            n_errors++;
            $display("FAIL stream_second: got v=%b pc=%h ins=%h expected 1/00000004/E3A000C8",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        step();
        n_checks++;
        if (bus.out_pc !== 32'h8 || bus.out_pcplus8 !== 32'h10) begin
            n_errors++;
            $display("FAIL stream_third: got pc=%h p8=%h expected 00000008/00000010", bus.out_pc, bus.out_pcplus8);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bus.fetch_count !== 32'd2 || bus.imem_addr !== 32'h8) begin
            n_errors++;
            $display("FAIL bp_stall: got fcnt=%0d addr=%h expected 2/00000008", bus.fetch_count, bus.imem_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'hE3A0_9000) begin
            n_errors++;
            $display("FAIL bp_head: got v=%b pc=%h ins=%h expected 1/00000000/E3A09000", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4)) begin
                n_errors++;
                $display("FAIL bp_release_%0d: got v=%b pc=%h expected 1/%h", i, bus.out_valid, bus.out_pc, 32'(i * 4));
            end
            step();
        end
    endtask

    task automatic test_full_pop();
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.fetch_count !== 32'd3 || bus.out_pc !== 32'h4 || bus.imem_addr !== 32'hC) begin
            n_errors++;
            $display("FAIL full_pop: got fcnt=%0d pc=%h addr=%h expected 3/00000004/0000000C",
                     bus.fetch_count, bus.out_pc, bus.imem_addr);
        end
        step();
        n_checks++;
        if (bus.fetch_count !== 32'd3 || bus.imem_addr !== 32'hC) begin
            n_errors++;
            $display("FAIL full_still_full: got fcnt=%0d addr=%h expected 3/0000000C", bus.fetch_count, bus.imem_addr);
        end
    endtask

    // Runs straight after test_full_pop: FIFO holds pc 4 and 8, fetch_count 3.
    task automatic test_redirect();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_005E;
        step();
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h5C || bus.fetch_count !== 32'd3) begin
            n_errors++;
            $display("FAIL redirect_flush: got v=%b addr=%h fcnt=%0d expected 0/0000005C/3",
                     bus.out_valid, bus.imem_addr, bus.fetch_count);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h5C || bus.out_instr !== 32'hEAFF_FFFE) begin
            n_errors++;
            $display("FAIL redirect_target: got v=%b pc=%h ins=%h expected 1/0000005C/EAFFFFFE",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        step();
        bus.redirect_pc = 32'h0000_0207;
        step();
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h204) begin
            n_errors++;
            $display("FAIL b2b_flush: got v=%b addr=%h expected 0/00000204", bus.out_valid, bus.imem_addr);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_instr !== 32'hA5A5_0204) begin
            n_errors++;
            $display("FAIL b2b_target: got v=%b pc=%h ins=%h expected 1/00000204/A5A50204",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_wrap();
        reset2_n         = 1'b0;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.out_ready   = 1'b1;
        step();
        reset2_n = 1'b1;
        n_checks++;
        if (bus2.imem_addr !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_reset_addr: got %h expected FFFFFFFC", bus2.imem_addr);
        end
        step();
        n_checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_pc !== 32'hFFFF_FFFC || bus2.out_pcplus8 !== 32'h4 ||
            bus2.out_instr !== 32'hA5A5_FFFC) begin
            n_errors++;
            $display("FAIL wrap_first: got v=%b pc=%h p8=%h ins=%h expected 1/FFFFFFFC/00000004/A5A5FFFC",
                     bus2.out_valid, bus2.out_pc, bus2.out_pcplus8, bus2.out_instr);
        end
        step();
        n_checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_pc !== 32'h0 || bus2.out_instr !== 32'hE3A0_9000) begin
            n_errors++;
            $display("FAIL wrap_second: got v=%b pc=%h ins=%h expected 1/00000000/E3A09000",
                     bus2.out_valid, bus2.out_pc, bus2.out_instr);
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = i[0];
            step();
        end
        reset_n         = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        bus.out_ready   = 1'b1;
        step();
        reset_n      = 1'b1;
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.fetch_count !== 32'h0 || bus.imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset: got v=%b fcnt=%0d addr=%h expected 0/0/00000000",
                     bus.out_valid, bus.fetch_count, bus.imem_addr);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.fetch_count !== 32'd1) begin
            n_errors++;
            $display("FAIL midreset_restart: got v=%b pc=%h fcnt=%0d expected 1/00000000/1",
                     bus.out_valid, bus.out_pc, bus.fetch_count);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        reset2_n         = 1'b0;
        bus.out_ready    = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus2.out_ready   = 1'b0;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = 32'h0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
